// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential multiplier controller.
package mult8_seq_ctrl_pkg;

   // Default operand width; must be even so it splits into two equal halves.
   localparam int unsigned W_DEFAULT = 8;

   // Number of partial-product steps per operation (LL, LH, HL, HH).
   localparam int unsigned N_STEPS = 4;

   // Controller states.
   typedef enum logic [2:0] {
      IDLE,
      S_LL,
      S_LH,
      S_HL,
      S_HH,
      DONE
   } state_t;

   // Left shift applied to the partial product of each step, for core width h.
   // Step order is LL, LH, HL, HH -> shifts 0, h, h, 2h.
   function automatic int unsigned pp_shift(input int unsigned step,
                                            input int unsigned h);
      int unsigned sh;
      sh = 0;
      case (step)
         0:       sh = 0;
         1:       sh = h;
         2:       sh = h;
         3:       sh = 2 * h;
         default: sh = 0;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mult8_seq_ctrl_mult_half_core.sv
// Combinational H x H -> 2H unsigned multiplier core.
// Any generated half-width multiplier with ports A, B, P can replace this body.
module mult_half_core #(
   parameter int unsigned H = 4
) (
   input  logic [H-1:0]   A,
   input  logic [H-1:0]   B,
   output logic [2*H-1:0] P
);

   // Product is evaluated at the full 2H result width, so no bits are lost.
   always_comb begin
      P = {{H{1'b0}}, A} * {{H{1'b0}}, B};
   end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential W x W unsigned multiplier: one shared (W/2)x(W/2) core is reused
// over four cycles (LL, LH, HL, HH) and the partial products are summed into a
// 2W-bit accumulator. Valid/ready on both the operand and result sides.
module mult8_seq_ctrl
   import mult8_seq_ctrl_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] p,
   output logic           busy
);

   localparam int unsigned H = W / 2;

   state_t           state;
   state_t           state_next;

   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   acc_next;

   logic [H-1:0]     core_a;
   logic [H-1:0]     core_b;
   logic [2*H-1:0]   pp;
   logic [2*W-1:0]   pp_ext;
   int unsigned      shift;

   logic             accept;
   logic             step_active;

   assign accept = in_valid && in_ready;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: fixed four-step walk, then wait in DONE for the consumer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = accept ? S_LL : IDLE;
         S_LL:    state_next = S_LH;
         S_LH:    state_next = S_HL;
         S_HL:    state_next = S_HH;
         S_HH:    state_next = DONE;
         DONE: begin
            if (out_ready) begin
               state_next = accept ? S_LL : IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake and status outputs, decoded from state (in_ready never sees in_valid).
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Core operand selection and shift amount for the current step.
   always_comb begin
      core_a      = a_q[H-1:0];
      core_b      = b_q[H-1:0];
      shift       = 0;
      step_active = 1'b0;
      case (state)
         S_LL: begin
            core_a      = a_q[H-1:0];
            core_b      = b_q[H-1:0];
            shift       = pp_shift(0, H);
            step_active = 1'b1;
         end
         S_LH: begin
            core_a      = a_q[H-1:0];
            core_b      = b_q[W-1:H];
            shift       = pp_shift(1, H);
            step_active = 1'b1;
         end
         S_HL: begin
            core_a      = a_q[W-1:H];
            core_b      = b_q[H-1:0];
            shift       = pp_shift(2, H);
            step_active = 1'b1;
         end
         S_HH: begin
            core_a      = a_q[W-1:H];
            core_b      = b_q[W-1:H];
            shift       = pp_shift(3, H);
            step_active = 1'b1;
         end
         default: begin
            core_a      = a_q[H-1:0];
            core_b      = b_q[H-1:0];
            shift       = 0;
            step_active = 1'b0;
         end
      endcase
   end

   mult_half_core #(
      .H (H)
   ) u_core (
      .A (core_a),
      .B (core_b),
      .P (pp)
   );

   // Accumulator update: the LL step restarts the sum, later steps add shifted terms.
   always_comb begin
      pp_ext = {{W{1'b0}}, pp};
      if (state == S_LL) begin
         acc_next = pp_ext;
      end else begin
         acc_next = acc + (pp_ext << shift);
      end
   end

   // Operand capture, accumulation, and result register (loaded as HH completes).
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         acc <= '0;
         p   <= '0;
      end else begin
         if (accept) begin
            a_q <= a;
            b_q <= b;
         end
         if (step_active) begin
            acc <= acc_next;
         end
         if (state == S_HH) begin
            p <= acc_next;
         end
      end
   end

endmodule
